// File: rtl/hazard_scoreboard.sv
// Load-use hazard scoreboard for the ID stage.
// Tracks per-register load latency and stalls dependent ID instructions.
module hazard_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs1_id,
    input  logic [REG_AW-1:0] rs2_id,
    input  logic              rs1_used_id,
    input  logic              rs2_used_id,
    input  logic              flush_id,
    input  logic              valid_ex,
    input  logic              MemRead_ex,
    input  logic              RegWrite_ex,
    input  logic [REG_AW-1:0] rd_ex,
    input  logic              mem_ready,
    input  logic              stat_clr,
    output logic              load_delay,
    output logic              PCWrite,
    output logic              IF_ID_Write,
    output logic [CNT_W-1:0]  stall_count,
    output logic              pending_any
);

    localparam int NREG = 1 << REG_AW;
    localparam logic [2:0] SET_VAL = 3'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [2:0] pend [NREG];
    logic       load_issue;
    logic       src1_hz;
    logic       src2_hz;
    logic       hazard;

    // Hazard detection: the load still in EX or any outstanding countdown.
    always_comb begin
        load_issue = valid_ex & MemRead_ex & RegWrite_ex
                   & (rd_ex != '0);
        src1_hz = rs1_used_id & (rs1_id != '0)
                & ((load_issue & (rd_ex == rs1_id))
                   | (pend[rs1_id] != 3'd0));
        src2_hz = rs2_used_id & (rs2_id != '0)
                & ((load_issue & (rd_ex == rs2_id))
                   | (pend[rs2_id] != 3'd0));
        hazard      = !flush_id & (src1_hz | src2_hz);
        load_delay  = hazard;
        PCWrite     = !hazard;
        IF_ID_Write = !hazard;
    end

    // Countdown per register; a new load to the same rd reloads the entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                pend[r] <= 3'd0;
            end
        end else if (mem_ready) begin
            for (int r = 1; r < NREG; r++) begin
                if (load_issue && (rd_ex == REG_AW'(r))) begin
                    pend[r] <= SET_VAL;
                end else if (pend[r] != 3'd0) begin
                    pend[r] <= pend[r] - 3'd1;
                end
            end
        end
    end

    // Any outstanding countdown.
    always_comb begin
        pending_any = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            pending_any = pending_any | (pend[r] != 3'd0);
        end
    end

    // Saturating stall statistic; clear has priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stat_clr) begin
            stall_count <= '0;
        end else if (hazard && (stall_count != CNT_MAX)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have parameter REG_AW, default 5, meaning register-address width (2**REG_AW architectural registers; register 0 hardwired zero).
REQ-002 The block SHALL have parameter LOAD_LAT, default 2, meaning cycles from load leaving EX until its data is forwardable; legal range 1..7.
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning stall-statistics counter width.
REQ-004 Ports SHALL be, one per line: name  direction  width  meaning:
  clk  in  1  sole clock; all state updates on rising edge.
  reset  in  1  asynchronous, active-high reset.
  rs1_id  in  REG_AW  source 1 of instruction in ID.
  rs2_id  in  REG_AW  source 2 of instruction in ID.
  rs1_used_id  in  1  ID instruction reads rs1.
  rs2_used_id  in  1  ID instruction reads rs2.
  flush_id  in  1  ID instruction is being killed this cycle (taken branch/jump).
  valid_ex  in  1  EX holds a real instruction (not a bubble).
  MemRead_ex  in  1  EX instruction is a load.
  RegWrite_ex  in  1  EX instruction writes rd.
  rd_ex  in  REG_AW  destination of EX instruction.
  mem_ready  in  1  pipeline advances this cycle (0 = global memory stall).
  stat_clr  in  1  synchronous clear of stall_count.
  load_delay  out  1  insert bubble into ID/EX this cycle.
  PCWrite  out  1  PC may update.
  IF_ID_Write  out  1  IF/ID register may update.
  stall_count  out  CNT_W  saturating count of load_delay cycles.
  pending_any  out  1  at least one scoreboard entry nonzero.

Function
REQ-005 The block SHALL hold one countdown pend[r] (width 3) per register r, r in 1..2**REG_AW-1; pend[0] SHALL be absent or constant 0.
REQ-006 Load issue SHALL be defined as valid_ex & MemRead_ex & RegWrite_ex & (rd_ex != 0).
REQ-007 ex_match(rs) SHALL be load issue & (rd_ex == rs), combinational.
REQ-008 src_hazard(rs, used) SHALL be used & (rs != 0) & (ex_match(rs) | pend[rs] != 0).
REQ-009 hazard SHALL equal !flush_id & (src_hazard(rs1_id, rs1_used_id) | src_hazard(rs2_id, rs2_used_id)).
REQ-010 Outputs SHALL be combinational from current inputs and state: load_delay = hazard, PCWrite = !hazard, IF_ID_Write = !hazard.
REQ-011 On a rising edge with mem_ready=1 and load issue, pend[rd_ex] SHALL load LOAD_LAT-1.
REQ-012 On a rising edge with mem_ready=1, every other nonzero pend[r] SHALL decrement by 1; zero entries SHALL stay zero.
REQ-013 Simultaneous set and decrement of the same entry SHALL resolve as set (newest load wins, WAW).
REQ-014 With mem_ready=0, all pend entries SHALL hold, and a load issue SHALL NOT set any entry (load remains in EX; ex_match keeps covering it).
REQ-015 Net effect: a consumer in ID with a load in EX at cycle t SHALL stall exactly cycles t..t+LOAD_LAT-1 when mem_ready stays 1; LOAD_LAT=1 SHALL reproduce the classic single-bubble load-use stall.
REQ-016 flush_id=1 SHALL force load_delay=0 but SHALL NOT alter pend updates.
REQ-017 stall_count SHALL increment by 1 on each rising edge where load_delay=1, saturate at 2**CNT_W-1, and clear to 0 when stat_clr=1 (clear wins over increment).
REQ-018 pending_any SHALL be the OR of all pend entries (combinational from state).

Reset
REQ-019 While reset=1, all pend entries and stall_count SHALL be 0 immediately, regardless of clk.
REQ-020 After reset with no load in EX: load_delay=0, PCWrite=1, IF_ID_Write=1, pending_any=0.
REQ-021 Reset asserted mid-countdown SHALL discard all pending entries; the first post-reset cycle SHALL show no residual stall.

Verification
REQ-022 LOAD_LAT=2: load x5 in EX at t, ID uses rs1=5 held stalled -> load_delay=1 at t and t+1, 0 at t+2; stall_count=2.
REQ-023 LOAD_LAT=1: load x7 in EX, ID rs2=7 used -> exactly one stall cycle; pend never nonzero; pending_any stays 0.
REQ-024 Load to x0, or ID rs1=5 with rs1_used_id=0, or flush_id=1 -> load_delay=0, stall_count unchanged.
REQ-025 LOAD_LAT=3, load x9 issued, mem_ready=0 for 2 cycles after set -> pend[9] holds at 2 during freeze; total stall cycles = 3 + 2 frozen cycles.
REQ-026 Back-to-back loads to x4 at t and t+1 (LOAD_LAT=3) -> pend[4] reloads to 2 at t+2; consumer released at t+4.
REQ-027 stall_count preset near max (CNT_W=4, 15 stalls) -> holds at 15; stat_clr with load_delay=1 -> 0.
